fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request handshake. It delivers fetched instructions to the IF/ID boundary and holds them while the hazard unit stalls. It applies branch and jump redirects, discards in-flight fetches, and pulses a flush to the IF/ID register. It replaces ad-hoc PC-write gating with one state machine between the hazard unit, branch/jump resolution and instruction memory.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_ctrl_sat_counter.sv | 30 +++
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch sequencer.
package fetch_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  // Branch (older instruction) wins over jump; targets are word aligned.
  function automatic logic [31:0] redirect_sel(input logic        br_taken,
                                               input logic [31:0] br_target,
                                               input logic [31:0] jmp_target);
    logic [31:0] t;
    t = br_taken ? br_target : jmp_target;
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem handshake,
// holds the IF/ID slot under stall and applies branch/jump redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jmp,
  input  logic [31:0]      jmp_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      pc,
  output logic             pc_wr,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] buf_q, buf_d;
  logic        pc_wr_q, pc_wr_d;
  logic        flush_q, flush_d;

  logic        redirect;
  logic [31:0] tgt;

  assign redirect = br_taken | jmp;
  assign tgt      = redirect_sel(br_taken, br_target, jmp_target);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q & stall;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    buf_d      = buf_q;
    pc_wr_d    = 1'b0;
    flush_d    = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          if (if_valid_q && stall) begin
            // Slot still occupied: park the word until downstream accepts.
            buf_d   = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_INC;
            pc_wr_d    = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          if_instr_d = buf_q;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PC_INC;
          pc_wr_d    = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_BOOT;
    endcase

    // Redirect overrides stall and any capture decided above.
    if (redirect) begin
      pc_d       = tgt;
      pc_wr_d    = 1'b1;
      flush_d    = 1'b1;
      if_valid_d = 1'b0;
      buf_d      = '0;
      if (state_q == ST_FETCH && !imem_ack) begin
        state_d = ST_DRAIN;
      end else if (state_q != ST_DRAIN) begin
        state_d = ST_FETCH;
      end
    end

    imem_req_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    imem_addr_d = (state_d == ST_FETCH) ? pc_d : imem_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      buf_q       <= '0;
      pc_wr_q     <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      buf_q       <= buf_d;
      pc_wr_q     <= pc_wr_d;
      flush_q     <= flush_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall & if_valid_q),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign pc        = pc_q;
  assign pc_wr     = pc_wr_q;
  assign flush     = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table, corner sequences and
// a randomized stream checked against an in-order delivery scoreboard.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall, br_taken, jmp, imem_ack;
  logic [31:0] br_target, jmp_target, imem_rdata;
  logic        imem_req, if_valid, pc_wr, flush;
  logic [31:0] imem_addr, if_instr, if_pc, pc;
  logic [15:0] stall_cnt;

  logic       sat_rst, sat_inc, sat_clr;
  logic [2:0] sat_cnt;

  int n_cmp;
  int n_fail;

  fetch_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .pc(pc), .pc_wr(pc_wr), .flush(flush), .stall_cnt(stall_cnt)
  );

  sat_counter #(.W(3)) u_sat (
    .clk(clk), .rst(sat_rst), .inc(sat_inc), .clear(sat_clr), .cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic [31:0] pc;
    logic        fl;
    logic        wr;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t tbl[16];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic [31:0] rd,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    stall = s; imem_ack = a; imem_rdata = rd;
    br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        s, a;
    logic [31:0] rd;
    exp_t        e;
    string       nm;
    n_cmp = 0;
    n_fail = 0;
    sat_rst = 1'b1; sat_inc = 1'b0; sat_clr = 1'b0;

    //         stall ack rdata         br bt            jmp jt           req addr          v  instr         ifpc          pc            fl wr cnt
    tbl[0]  = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 32'h0000_3000, 0, 32'h0,         32'h0,         32'h0000_3000, 0, 0, 16'd0};
    tbl[1]  = '{0, 1, 32'hA000_0000, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3004, 1, 32'hA000_0000, 32'h0000_3000, 32'h0000_3004, 0, 1, 16'd0};
    tbl[2]  = '{0, 1, 32'hA000_0001, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3008, 1, 32'hA000_0001, 32'h0000_3004, 32'h0000_3008, 0, 1, 16'd0};
    tbl[3]  = '{1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 32'h0000_3008, 1, 32'hA000_0001, 32'h0000_3004, 32'h0000_3008, 0, 0, 16'd1};
    tbl[4]  = '{1, 1, 32'hA000_0002, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3008, 1, 32'hA000_0001, 32'h0000_3004, 32'h0000_3008, 0, 0, 16'd2};
    tbl[5]  = '{1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 32'h0000_3008, 1, 32'hA000_0001, 32'h0000_3004, 32'h0000_3008, 0, 0, 16'd3};
    tbl[6]  = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 32'h0000_300C, 1, 32'hA000_0002, 32'h0000_3008, 32'h0000_300C, 0, 1, 16'd3};
    tbl[7]  = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 32'h0000_300C, 0, 32'hA000_0002, 32'h0000_3008, 32'h0000_300C, 0, 0, 16'd3};
    tbl[8]  = '{0, 0, 32'h0,         1, 32'h0000_3101, 0, 32'h0,       1, 32'h0000_300C, 0, 32'hA000_0002, 32'h0000_3008, 32'h0000_3100, 1, 1, 16'd3};
    tbl[9]  = '{0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 32'h0000_300C, 0, 32'hA000_0002, 32'h0000_3008, 32'h0000_3100, 0, 0, 16'd3};
    tbl[10] = '{0, 1, 32'hDEAD_BEEF, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3100, 0, 32'hA000_0002, 32'h0000_3008, 32'h0000_3100, 0, 0, 16'd3};
    tbl[11] = '{0, 0, 32'h0,         1, 32'h0000_4000, 1, 32'h0000_5000, 1, 32'h0000_3100, 0, 32'hA000_0002, 32'h0000_3008, 32'h0000_4000, 1, 1, 16'd3};
    tbl[12] = '{0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_6003, 1, 32'h0000_3100, 0, 32'hA000_0002, 32'h0000_3008, 32'h0000_6000, 1, 1, 16'd3};
    tbl[13] = '{0, 1, 32'hDEAD_BEEF, 0, 32'h0,        0, 32'h0,        1, 32'h0000_6000, 0, 32'hA000_0002, 32'h0000_3008, 32'h0000_6000, 0, 0, 16'd3};
    tbl[14] = '{0, 1, 32'hA000_0003, 0, 32'h0,        0, 32'h0,        1, 32'h0000_6004, 1, 32'hA000_0003, 32'h0000_6000, 32'h0000_6004, 0, 1, 16'd3};
    tbl[15] = '{1, 1, 32'hDEAD_BEEF, 0, 32'h0,        1, 32'h0000_7000, 1, 32'h0000_7000, 0, 32'hA000_0003, 32'h0000_6000, 32'h0000_7000, 1, 1, 16'd4};

    // Reset values while rst is held
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst.pc", pc, 32'h0000_3000);
    chk("rst.req", 32'(imem_req), 32'h0);
    chk("rst.addr", imem_addr, 32'h0000_3000);
    chk("rst.valid", 32'(if_valid), 32'h0);
    chk("rst.instr", if_instr, 32'h0);
    chk("rst.ifpc", if_pc, 32'h0);
    chk("rst.flags", {30'h0, pc_wr, flush}, 32'h0);
    chk("rst.cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].stall, tbl[i].ack, tbl[i].rdata, tbl[i].br, tbl[i].bt, tbl[i].jmp, tbl[i].jt);
      @(negedge clk);
      nm = $sformatf("v%0d", i);
      chk({nm, ".req"},   32'(imem_req), 32'(tbl[i].req));
      chk({nm, ".addr"},  imem_addr,     tbl[i].addr);
      chk({nm, ".valid"}, 32'(if_valid), 32'(tbl[i].valid));
      chk({nm, ".instr"}, if_instr,      tbl[i].instr);
      chk({nm, ".ifpc"},  if_pc,         tbl[i].ifpc);
      chk({nm, ".pc"},    pc,            tbl[i].pc);
      chk({nm, ".flush"}, 32'(flush),    32'(tbl[i].fl));
      chk({nm, ".pc_wr"}, 32'(pc_wr),    32'(tbl[i].wr));
      chk({nm, ".cnt"},   32'(stall_cnt), 32'(tbl[i].cnt));
    end

    // Ack delayed three cycles: request and address held
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("dly%0d.req", k), 32'(imem_req), 32'h1);
      chk($sformatf("dly%0d.addr", k), imem_addr, 32'h0000_3000);
      chk($sformatf("dly%0d.valid", k), 32'(if_valid), 32'h0);
      drive(0, (k == 3), 32'hB000_0000, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk("dly.valid", 32'(if_valid), 32'h1);
    chk("dly.ifpc", if_pc, 32'h0000_3000);
    chk("dly.instr", if_instr, 32'hB000_0000);

    // Five stall cycles with a valid slot, second word parked in HOLD
    do_reset();
    @(negedge clk);
    drive(0, 1, 32'hC000_0000, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 32'hC000_0001, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("stl.cnt", 32'(stall_cnt), 32'd5);
    chk("stl.ifpc", if_pc, 32'h0000_3000);
    chk("stl.instr", if_instr, 32'hC000_0000);
    chk("stl.pc", pc, 32'h0000_3004);
    chk("stl.req", 32'(imem_req), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stl.rel_instr", if_instr, 32'hC000_0001);
    chk("stl.rel_ifpc", if_pc, 32'h0000_3004);
    chk("stl.rel_pc", pc, 32'h0000_3008);
    chk("stl.rel_wr", 32'(pc_wr), 32'h1);
    chk("stl.rel_cnt", 32'(stall_cnt), 32'd5);

    // PC wraps modulo 2^32
    do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap.pc0", pc, 32'hFFFF_FFFC);
    drive(0, 1, 32'hDEAD_0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    drive(0, 1, 32'hE000_0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap.pc", pc, 32'h0000_0000);
    chk("wrap.addr", imem_addr, 32'h0000_0000);
    chk("wrap.ifpc", if_pc, 32'hFFFF_FFFC);
    chk("wrap.instr", if_instr, 32'hE000_0000);

    // Asynchronous reset while draining
    do_reset();
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h0000_3200, 0, 0);
    @(negedge clk);
    chk("rdr.pc", pc, 32'h0000_3200);
    chk("rdr.req", 32'(imem_req), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rdr.rst_pc", pc, 32'h0000_3000);
    chk("rdr.rst_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Random stall/ack stream: every acked word must be delivered in order
    do_reset();
    for (int c = 0; c < 406; c++) begin
      @(negedge clk);
      s = (c < 400) && ($urandom_range(0, 3) == 0);
      if (if_valid && !s) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stream.empty: got pc %h expected no delivery", if_pc);
        end else begin
          e = sb.pop_front();
          chk("stream.pc", if_pc, e.pc);
          chk("stream.instr", if_instr, e.instr);
        end
      end
      a = (c < 400) && imem_req && ($urandom_range(0, 1) == 1);
      rd = imem_addr ^ 32'h5A5A_0F0F;
      if (a) sb.push_back('{imem_addr, rd});
      drive(s, a, rd, 0, 0, 0, 0);
    end
    chk("stream.left", 32'(sb.size()), 32'd0);

    // Saturation of the counter primitive
    @(negedge clk);
    sat_rst = 1'b0;
    sat_inc = 1'b1;
    repeat (9) @(negedge clk);
    chk("sat.top", 32'(sat_cnt), 32'd7);
    sat_inc = 1'b0;
    sat_clr = 1'b1;
    @(negedge clk);
    chk("sat.clr", 32'(sat_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
